multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 44 ++++
 rtl/multicycle_decode.sv | 66 ++++++
 rtl/multicycle_control.sv | 168 ++++++++++++++++
 tb/tb_multicycle_control.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the FSM state encoding, the legal opcode constants, the ALU
// operation-class codes, the next-PC select codes and the internal
// instruction-class tags produced by the decoder. The controller, the
// decoder and the testbench all import this package so they agree on values.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Instruction classes; LUI and OP-IMM share the ALU -> WB path.
    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_JAL    = 3'd3,
        CLS_LOAD   = 3'd4,
        CLS_STORE  = 3'd5
    } instr_class_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_PASS       = 3'b000;
    localparam logic [2:0] ALU_CMP        = 3'b001;
    localparam logic [2:0] ALU_LOAD_ADDR  = 3'b010;
    localparam logic [2:0] ALU_STORE_ADDR = 3'b011;
    localparam logic [2:0] ALU_IMM        = 3'b100;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_decode.sv
// Combinational opcode decoder for the multicycle controller.
// Ports:
//   opcode  in  7  instruction[6:0]
//   legal   out 1  opcode is one of the supported instructions
//   alu_op  out 3  ALU operation class (0 for illegal opcodes)
//   alu_src out 1  1 = immediate operand, 0 = rs2 (BRANCH only)
//   cls     out 3  instr_class_t tag that steers the FSM
module multicycle_decode
    import multicycle_control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic [2:0] alu_op,
    output logic       alu_src,
    output logic [2:0] cls
);

    always_comb begin
        legal   = 1'b0;
        alu_op  = ALU_PASS;
        alu_src = 1'b0;
        cls     = CLS_NONE;
        case (opcode)
            OPC_LUI: begin
                legal   = 1'b1;
                alu_op  = ALU_PASS;
                alu_src = 1'b1;
                cls     = CLS_ALU;
            end
            OPC_BRANCH: begin
                legal   = 1'b1;
                alu_op  = ALU_CMP;
                alu_src = 1'b0;
                cls     = CLS_BRANCH;
            end
            OPC_LOAD: begin
                legal   = 1'b1;
                alu_op  = ALU_LOAD_ADDR;
                alu_src = 1'b1;
                cls     = CLS_LOAD;
            end
            OPC_STORE: begin
                legal   = 1'b1;
                alu_op  = ALU_STORE_ADDR;
                alu_src = 1'b1;
                cls     = CLS_STORE;
            end
            OPC_OPIMM: begin
                legal   = 1'b1;
                alu_op  = ALU_IMM;
                alu_src = 1'b1;
                cls     = CLS_ALU;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                alu_op  = ALU_PASS;
                alu_src = 1'b1;
                cls     = CLS_JAL;
            end
            default: begin
                legal   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction, drives
// the datapath strobes, counts retired instructions (one per pc_we pulse) and
// latches a sticky illegal flag when an unsupported opcode reaches DECODE.
// Ports:
//   clk, reset (async, active-high)
//   opcode, branch_taken, mem_ready            inputs from datapath / memory
//   ir_we, pc_we, pc_src, reg_write            datapath strobes
//   alu_op, alu_src, mem_to_reg                decoded datapath selects
//   mem_req, mem_we                            data-memory request
//   state, illegal, retired                    status / debug
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [2:0]       alu_op,
    output logic             alu_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q;
    state_t           state_d;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;

    logic             dec_legal;
    logic [2:0]       dec_alu_op;
    logic             dec_alu_src;
    logic [2:0]       dec_cls;
    instr_class_t     cls;

    multicycle_decode u_decode (
        .opcode  (opcode),
        .legal   (dec_legal),
        .alu_op  (dec_alu_op),
        .alu_src (dec_alu_src),
        .cls     (dec_cls)
    );

    assign cls = instr_class_t'(dec_cls);

    // State register, retired counter and sticky illegal flag.
    // The illegal flag is set on the DECODE edge that enters TRAP, so it is
    // already high in the first TRAP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE && !dec_legal) begin
                illegal_q <= 1'b1;
            end
            if (pc_we) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state and output decode.
    // Strobes are gated by reset so they fall immediately on assertion,
    // without waiting for the state register to settle into FETCH.
    always_comb begin
        state_d    = state_q;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_PLUS4;
        reg_write  = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        alu_op     = ALU_PASS;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;

        if (state_q == ST_DECODE || state_q == ST_EXEC ||
            state_q == ST_MEM    || state_q == ST_WB) begin
            alu_op     = dec_alu_op;
            alu_src    = dec_alu_src;
            mem_to_reg = (cls == CLS_LOAD);
        end

        case (state_q)
            ST_FETCH: begin
                ir_we   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (cls)
                    CLS_ALU: begin
                        state_d = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        state_d = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = branch_taken ? PC_BRANCH : PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                    CLS_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_JUMP;
                        state_d = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (cls == CLS_STORE);
                if (mem_ready) begin
                    if (cls == CLS_STORE) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_TRAP;
            end
        endcase

        if (reset) begin
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_src    = PC_PLUS4;
            reg_write = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control.
// A per-cycle vector table walks OP-IMM, LOAD, two BRANCHes, JAL, LUI, STORE
// and an illegal opcode; hand-written sequences cover the TRAP hold, a reset
// during a STORE memory wait, and counter wrap on a CNT_W = 4 instance.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct {
        logic [6:0]  opcode;
        logic        branch_taken;
        logic        mem_ready;
        logic [2:0]  st;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_src;
        logic        reg_write;
        logic        mem_req;
        logic        mem_we;
        logic [2:0]  alu_op;
        logic        alu_src;
        logic        mem_to_reg;
        logic        illegal;
        logic [15:0] retired;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [2:0]  alu_op;
    logic        alu_src;
    logic        mem_req;
    logic        mem_we;
    logic        mem_to_reg;
    logic [2:0]  state;
    logic        illegal;
    logic [15:0] retired;

    logic        ir_we4;
    logic        pc_we4;
    logic [1:0]  pc_src4;
    logic        reg_write4;
    logic [2:0]  alu_op4;
    logic        alu_src4;
    logic        mem_req4;
    logic        mem_we4;
    logic        mem_to_reg4;
    logic [2:0]  state4;
    logic        illegal4;
    logic [3:0]  retired4;

    int   tests_run = 0;
    int   failed    = 0;
    vec_t vecs [36];

    multicycle_control #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .alu_op       (alu_op),
        .alu_src      (alu_src),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_to_reg   (mem_to_reg),
        .state        (state),
        .illegal      (illegal),
        .retired      (retired)
    );

    // Narrow-counter instance that only ever sees LUI.
    multicycle_control #(.CNT_W(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .opcode       (OPC_LUI),
        .branch_taken (1'b0),
        .mem_ready    (1'b0),
        .ir_we        (ir_we4),
        .pc_we        (pc_we4),
        .pc_src       (pc_src4),
        .reg_write    (reg_write4),
        .alu_op       (alu_op4),
        .alu_src      (alu_src4),
        .mem_req      (mem_req4),
        .mem_we       (mem_we4),
        .mem_to_reg   (mem_to_reg4),
        .state        (state4),
        .illegal      (illegal4),
        .retired      (retired4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic [6:0] op, input logic bt, input logic mr, input logic [2:0] st,
        input logic ir, input logic pcw, input logic [1:0] pcs, input logic rw,
        input logic mreq, input logic mwe, input logic [2:0] alu, input logic asrc,
        input logic m2r, input logic ill, input logic [15:0] ret);
        vec_t v;
        v.opcode = op; v.branch_taken = bt; v.mem_ready = mr; v.st = st;
        v.ir_we = ir; v.pc_we = pcw; v.pc_src = pcs; v.reg_write = rw;
        v.mem_req = mreq; v.mem_we = mwe; v.alu_op = alu; v.alu_src = asrc;
        v.mem_to_reg = m2r; v.illegal = ill; v.retired = ret;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        logic [31:0] got;
        logic [31:0] exp;
        got = {state, ir_we, pc_we, pc_src, reg_write, mem_req, mem_we,
               alu_op, alu_src, mem_to_reg, illegal, retired};
        exp = {v.st, v.ir_we, v.pc_we, v.pc_src, v.reg_write, v.mem_req, v.mem_we,
               v.alu_op, v.alu_src, v.mem_to_reg, v.illegal, v.retired};
        checkValue($sformatf("vec%0d", idx), got, exp);
    endtask

    // Called at a falling edge: drive, check, then advance one full cycle.
    task automatic applyStimulus(input int idx, input vec_t v);
        opcode       = v.opcode;
        branch_taken = v.branch_taken;
        mem_ready    = v.mem_ready;
        #1;
        checkOutput(idx, v);
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] ill_op;
        vec_t       v;
        ill_op = 7'b0110011;

        //              op          bt mr st         ir pcw pcs        rw mq mw alu             as m2r il ret
        vecs[0]  = mk(OPC_OPIMM,  0, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 0);
        vecs[1]  = mk(OPC_OPIMM,  0, 0, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_IMM,        1, 0, 0, 0);
        vecs[2]  = mk(OPC_OPIMM,  0, 0, ST_EXEC,   0, 0, PC_PLUS4,  0, 0, 0, ALU_IMM,        1, 0, 0, 0);
        vecs[3]  = mk(OPC_OPIMM,  0, 0, ST_WB,     0, 1, PC_PLUS4,  1, 0, 0, ALU_IMM,        1, 0, 0, 0);
        vecs[4]  = mk(OPC_LOAD,   0, 1, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 1);
        vecs[5]  = mk(OPC_LOAD,   0, 1, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_LOAD_ADDR,  1, 1, 0, 1);
        vecs[6]  = mk(OPC_LOAD,   0, 1, ST_EXEC,   0, 0, PC_PLUS4,  0, 0, 0, ALU_LOAD_ADDR,  1, 1, 0, 1);
        vecs[7]  = mk(OPC_LOAD,   0, 0, ST_MEM,    0, 0, PC_PLUS4,  0, 1, 0, ALU_LOAD_ADDR,  1, 1, 0, 1);
        vecs[8]  = mk(OPC_LOAD,   0, 0, ST_MEM,    0, 0, PC_PLUS4,  0, 1, 0, ALU_LOAD_ADDR,  1, 1, 0, 1);
        vecs[9]  = mk(OPC_LOAD,   0, 1, ST_MEM,    0, 0, PC_PLUS4,  0, 1, 0, ALU_LOAD_ADDR,  1, 1, 0, 1);
        vecs[10] = mk(OPC_LOAD,   0, 0, ST_WB,     0, 1, PC_PLUS4,  1, 0, 0, ALU_LOAD_ADDR,  1, 1, 0, 1);
        vecs[11] = mk(OPC_BRANCH, 1, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 2);
        vecs[12] = mk(OPC_BRANCH, 1, 0, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_CMP,        0, 0, 0, 2);
        vecs[13] = mk(OPC_BRANCH, 1, 0, ST_EXEC,   0, 1, PC_BRANCH, 0, 0, 0, ALU_CMP,        0, 0, 0, 2);
        vecs[14] = mk(OPC_BRANCH, 1, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 3);
        vecs[15] = mk(OPC_BRANCH, 1, 1, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_CMP,        0, 0, 0, 3);
        vecs[16] = mk(OPC_BRANCH, 0, 0, ST_EXEC,   0, 1, PC_PLUS4,  0, 0, 0, ALU_CMP,        0, 0, 0, 3);
        vecs[17] = mk(OPC_JAL,    1, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 4);
        vecs[18] = mk(OPC_JAL,    1, 0, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       1, 0, 0, 4);
        vecs[19] = mk(OPC_JAL,    1, 0, ST_EXEC,   0, 1, PC_JUMP,   0, 0, 0, ALU_PASS,       1, 0, 0, 4);
        vecs[20] = mk(OPC_LUI,    0, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 5);
        vecs[21] = mk(OPC_LUI,    0, 0, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       1, 0, 0, 5);
        vecs[22] = mk(OPC_LUI,    0, 0, ST_EXEC,   0, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       1, 0, 0, 5);
        vecs[23] = mk(OPC_LUI,    0, 0, ST_WB,     0, 1, PC_PLUS4,  1, 0, 0, ALU_PASS,       1, 0, 0, 5);
        vecs[24] = mk(OPC_STORE,  0, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 6);
        vecs[25] = mk(OPC_STORE,  0, 0, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_STORE_ADDR, 1, 0, 0, 6);
        vecs[26] = mk(OPC_STORE,  0, 0, ST_EXEC,   0, 0, PC_PLUS4,  0, 0, 0, ALU_STORE_ADDR, 1, 0, 0, 6);
        vecs[27] = mk(OPC_STORE,  0, 0, ST_MEM,    0, 0, PC_PLUS4,  0, 1, 1, ALU_STORE_ADDR, 1, 0, 0, 6);
        vecs[28] = mk(OPC_STORE,  0, 1, ST_MEM,    0, 1, PC_PLUS4,  0, 1, 1, ALU_STORE_ADDR, 1, 0, 0, 6);
        vecs[29] = mk(ill_op,     0, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 7);
        vecs[30] = mk(ill_op,     0, 0, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 7);
        vecs[31] = mk(ill_op,     0, 0, ST_TRAP,   0, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 1, 7);
        vecs[32] = mk(OPC_STORE,  0, 0, ST_FETCH,  1, 0, PC_PLUS4,  0, 0, 0, ALU_PASS,       0, 0, 0, 0);
        vecs[33] = mk(OPC_STORE,  0, 0, ST_DECODE, 0, 0, PC_PLUS4,  0, 0, 0, ALU_STORE_ADDR, 1, 0, 0, 0);
        vecs[34] = mk(OPC_STORE,  0, 0, ST_EXEC,   0, 0, PC_PLUS4,  0, 0, 0, ALU_STORE_ADDR, 1, 0, 0, 0);
        vecs[35] = mk(OPC_STORE,  0, 0, ST_MEM,    0, 0, PC_PLUS4,  0, 1, 1, ALU_STORE_ADDR, 1, 0, 0, 0);

        reset        = 1'b1;
        opcode       = OPC_OPIMM;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        #1;
        checkValue("reset_outputs", {26'd0, state, ir_we, pc_we, reg_write},
                   32'd0);
        checkValue("reset_status", {15'd0, illegal, retired}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // TRAP must hold with legal opcodes and toggling handshakes.
        for (int i = 0; i < 20; i++) begin
            v              = vecs[31];
            v.opcode       = OPC_LUI;
            v.branch_taken = 1'b1;
            v.mem_ready    = i[0];
            applyStimulus(100 + i, v);
        end

        reset = 1'b1;
        #1;
        checkValue("trap_reset", {28'd0, state, illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 32; i < 36; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Second MEM wait cycle of a STORE, then reset mid-cycle.
        opcode    = OPC_STORE;
        mem_ready = 1'b0;
        #1;
        checkValue("store_wait2", {26'd0, state, mem_req, mem_we, pc_we},
                   {26'd0, 3'd3, 1'b1, 1'b1, 1'b0});
        #1;
        reset = 1'b1;
        #1;
        checkValue("mid_reset_now", {25'd0, state, ir_we, pc_we, reg_write, mem_req},
                   32'd0);
        @(posedge clk);
        #1;
        checkValue("mid_reset_edge", {16'd0, 10'd0, state, pc_we, reg_write, mem_req, retired[0]},
                   32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkValue("release_fetch", {27'd0, state, ir_we, pc_we},
                   {27'd0, 3'd0, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        checkValue("release_decode", {29'd0, state}, {29'd0, 3'd1});

        // Counter wrap on the narrow instance: 4 cycles per LUI.
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkValue("cnt4_reset", {28'd0, retired4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        #1;
        checkValue("cnt4_after15", {28'd0, retired4}, 32'd15);
        repeat (4) @(negedge clk);
        #1;
        checkValue("cnt4_after16", {28'd0, retired4}, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        checkValue("cnt4_after17", {28'd0, retired4}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
